core_ctrl: RTL and testbench

Instruction sequencer for the core datapath. It drives the 35-bit `inst` bus and runs one full tile per `start` pulse. A tile is four steps: load weights from activation/weight SRAM into L0 and the PE array, stream activations through the array, then drain the output FIFO into psum SRAM. It sits directly above `core`, replacing testbench-driven instruction streams, and reports completion to the host.

---
 rtl/core_ctrl_pkg.sv | 36 +++
 rtl/ctrl_counter.sv | 37 +++
 rtl/core_ctrl.sv | 165 ++++++++++++++++
 tb/tb_core_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core tile sequencer: inst bus layout, idle word and FSM states.
package core_ctrl_pkg;

  localparam int unsigned InstW = 35;

  localparam int unsigned SfpEnBit   = 34;
  localparam int unsigned AccBit     = 33;
  localparam int unsigned CenPmemBit = 32;
  localparam int unsigned WenPmemBit = 31;
  localparam int unsigned APmemLsb   = 20;
  localparam int unsigned CenXmemBit = 19;
  localparam int unsigned WenXmemBit = 18;
  localparam int unsigned AXmemLsb   = 7;
  localparam int unsigned OfifoRdBit = 6;
  localparam int unsigned IfifoWrBit = 5;
  localparam int unsigned IfifoRdBit = 4;
  localparam int unsigned L0RdBit    = 3;
  localparam int unsigned L0WrBit    = 2;
  localparam int unsigned ExecuteBit = 1;
  localparam int unsigned LoadBit    = 0;

  // Both SRAMs deselected and in read mode, every strobe low.
  localparam logic [InstW-1:0] IdleInst = 35'h1_800c_0000;

  typedef enum logic [2:0] {
    StIdle,
    StWL0,
    StWLoad,
    StWDrain,
    StXL0,
    StExec,
    StOWr,
    StFinish
  } state_e;

endpackage

// File: rtl/ctrl_counter.sv
// Loadable up-counter with a terminal-count compare against a runtime limit.
module ctrl_counter #(
  parameter int unsigned addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [addr_bw-1:0] load_val,
  input  logic               inc,
  input  logic [addr_bw-1:0] limit,
  output logic [addr_bw-1:0] count,
  output logic               at_limit
);

  logic [addr_bw-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc) begin
      count_d = count_q + addr_bw'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign at_limit = (count_q == limit);

endmodule

// File: rtl/core_ctrl.sv
// Tile sequencer: drives the core inst bus through weight load, activation stream and
// output drain for one tile per accepted start pulse.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned row     = 8,
  parameter int unsigned col     = 8,
  parameter int unsigned addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic [addr_bw-1:0] n_x,
  input  logic               ofifo_valid,
  output logic [InstW-1:0]   inst,
  output logic               busy,
  output logic               done
);

  localparam logic [addr_bw-1:0] ColEnd  = addr_bw'(col);
  localparam logic [addr_bw-1:0] ColLast = addr_bw'(col - 1);
  localparam logic [addr_bw-1:0] RowLast = addr_bw'(row - 1);
  localparam logic [addr_bw-1:0] Zero    = '0;

  state_e             state_q, state_d;
  logic [addr_bw-1:0] w_base_q, x_base_q, p_base_q, n_x_q;
  logic [InstW-1:0]   inst_q, inst_d;
  logic               busy_q, done_q;
  logic               rd_q, rd_d;
  logic               accept, wr_fire;
  logic [addr_bw-1:0] ph_cnt, ph_limit, wr_cnt;
  logic               ph_tc, wr_tc;

  // busy_q lags state by a cycle; gating on it also blocks a start right after FINISH.
  assign accept  = (state_q == StIdle) && start && !busy_q;
  assign wr_fire = (state_q == StOWr) && ofifo_valid;

  ctrl_counter #(.addr_bw(addr_bw)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state_d != state_q),
    .load_val (Zero),
    .inc      (state_q != StIdle),
    .limit    (ph_limit),
    .count    (ph_cnt),
    .at_limit (ph_tc)
  );

  ctrl_counter #(.addr_bw(addr_bw)) u_wr_idx (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q != StOWr),
    .load_val (Zero),
    .inc      (wr_fire),
    .limit    (n_x_q - addr_bw'(1)),
    .count    (wr_cnt),
    .at_limit (wr_tc)
  );

  always_comb begin
    ph_limit = Zero;
    unique case (state_q)
      StWL0:    ph_limit = ColEnd;
      StWLoad:  ph_limit = ColLast;
      StWDrain: ph_limit = RowLast;
      StXL0:    ph_limit = n_x_q;
      StExec:   ph_limit = n_x_q - addr_bw'(1);
      default:  ph_limit = Zero;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StWL0;
      StWL0:    if (ph_tc) state_d = StWLoad;
      StWLoad:  if (ph_tc) state_d = StWDrain;
      StWDrain: if (ph_tc) state_d = (n_x_q == Zero) ? StFinish : StXL0;
      StXL0:    if (ph_tc) state_d = StExec;
      StExec:   if (ph_tc) state_d = StOWr;
      StOWr:    if (wr_fire && wr_tc) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    inst_d             = IdleInst;
    inst_d[SfpEnBit]   = 1'b0;
    inst_d[AccBit]     = 1'b0;
    inst_d[IfifoWrBit] = 1'b0;
    inst_d[IfifoRdBit] = 1'b0;
    // The last cycle of each L0 fill phase issues no read, only the trailing l0_wr.
    rd_d = ((state_q == StWL0) || (state_q == StXL0)) && !ph_tc;
    if (rd_d) begin
      inst_d[CenXmemBit]           = 1'b0;
      inst_d[WenXmemBit]           = 1'b1;
      inst_d[AXmemLsb +: addr_bw]  = ((state_q == StWL0) ? w_base_q : x_base_q) + ph_cnt;
    end
    inst_d[L0WrBit] = rd_q;
    unique case (state_q)
      StWLoad: begin
        inst_d[L0RdBit] = 1'b1;
        inst_d[LoadBit] = 1'b1;
      end
      StExec: begin
        inst_d[L0RdBit]    = 1'b1;
        inst_d[ExecuteBit] = 1'b1;
      end
      StOWr: begin
        if (ofifo_valid) begin
          inst_d[OfifoRdBit]          = 1'b1;
          inst_d[CenPmemBit]          = 1'b0;
          inst_d[WenPmemBit]          = 1'b0;
          inst_d[APmemLsb +: addr_bw] = p_base_q + wr_cnt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
      n_x_q    <= '0;
    end else if (accept) begin
      w_base_q <= w_base;
      x_base_q <= x_base;
      p_base_q <= p_base;
      n_x_q    <= n_x;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q <= IdleInst;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      inst_q <= inst_d;
      busy_q <= (state_q != StIdle);
      done_q <= (state_q == StFinish);
      rd_q   <= rd_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: directed tile table plus randomized tiles against a
// phase-duration reference model.
module tb_core_ctrl;
  import core_ctrl_pkg::*;

  localparam int Row    = 8;
  localparam int Col    = 8;
  localparam int AddrBw = 11;
  localparam int AMod   = 1 << AddrBw;
  localparam int MaxK   = 400;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [AddrBw-1:0] w_base, x_base, p_base, n_x;
  logic              ofifo_valid;
  logic [InstW-1:0]  inst;
  logic              busy, done;

  core_ctrl #(.row(Row), .col(Col), .addr_bw(AddrBw)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .w_base      (w_base),
    .x_base      (x_base),
    .p_base      (p_base),
    .n_x         (n_x),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int w;
    int x;
    int p;
    int n;
    int mode;     // 0: valid high, 1: 1,0,0 pattern in O_WR, 2: random
    bit poke;     // pulse start with new config mid-EXEC
    int exp_lat;  // -1: model only
  } vec_t;

  int vq[MaxK+1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic scramble_cfg();
    w_base = AddrBw'($urandom);
    x_base = AddrBw'($urandom);
    p_base = AddrBw'($urandom);
    n_x    = AddrBw'($urandom);
  endtask

  task automatic run_tile(input vec_t v);
    int rd_edge[$], rd_addr[$], wr_edge[$], wr_addr[$];
    int e_rd_edge[$], e_rd_addr[$], e_wr_edge[$], e_wr_addr[$];
    int s, done_k, exp_done, found, stalls;
    int l0wr_n, l0rd_n, load_n, exec_n, idle_n, stray, pair_err, busy_low, extra;
    bit rd, wr, prev_rd;
    s = 2*Col + Row + 3 + 2*v.n;
    done_k = -1;
    l0wr_n = 0; l0rd_n = 0; load_n = 0; exec_n = 0; idle_n = 0;
    stray = 0; pair_err = 0; busy_low = 0; prev_rd = 0;

    @(negedge clk);
    w_base = AddrBw'(v.w); x_base = AddrBw'(v.x);
    p_base = AddrBw'(v.p); n_x = AddrBw'(v.n);
    start = 1'b1; ofifo_valid = 1'b0;
    @(posedge clk); #1;
    check("busy_at_accept_edge", 64'(busy), 64'd0);
    check("inst_at_accept_edge", 64'(inst), 64'(IdleInst));

    for (int k = 1; k <= MaxK; k++) begin
      @(negedge clk);
      start = v.poke && (k == 33);
      scramble_cfg();
      case (v.mode)
        0:       ofifo_valid = 1'b1;
        1:       ofifo_valid = (k >= s) && (((k - s) % 3) == 0);
        default: ofifo_valid = 1'($urandom_range(0, 1));
      endcase
      vq[k] = int'(ofifo_valid);
      @(posedge clk); #1;
      rd = !inst[CenXmemBit] && inst[WenXmemBit];
      wr = !inst[CenPmemBit] && !inst[WenPmemBit];
      if (rd) begin
        rd_edge.push_back(k); rd_addr.push_back(int'(inst[AXmemLsb +: AddrBw]));
      end else if (inst[AXmemLsb +: AddrBw] != '0) stray++;
      if (wr) begin
        wr_edge.push_back(k); wr_addr.push_back(int'(inst[APmemLsb +: AddrBw]));
      end else if (inst[APmemLsb +: AddrBw] != '0) stray++;
      if (!inst[WenXmemBit]) stray++;
      if (inst[CenPmemBit] != inst[WenPmemBit]) stray++;
      if (inst[SfpEnBit] || inst[AccBit] || inst[IfifoWrBit] || inst[IfifoRdBit]) stray++;
      if (wr != inst[OfifoRdBit]) stray++;
      if (inst[L0WrBit] != prev_rd) pair_err++;
      prev_rd = rd;
      l0wr_n += int'(inst[L0WrBit]);
      l0rd_n += int'(inst[L0RdBit]);
      load_n += int'(inst[LoadBit]);
      exec_n += int'(inst[ExecuteBit]);
      if (inst[LoadBit] && inst[ExecuteBit]) stray++;
      if (inst == IdleInst) idle_n++;
      if (!busy) busy_low++;
      if (done) begin
        done_k = k;
        break;
      end
    end
    start = 1'b0;

    // Reference model: phase durations and address sequences straight from the tile rules.
    for (int k = 0; k < Col; k++) begin
      e_rd_edge.push_back(1 + k); e_rd_addr.push_back((v.w + k) % AMod);
    end
    for (int i = 0; i < v.n; i++) begin
      e_rd_edge.push_back(2*Col + Row + 2 + i); e_rd_addr.push_back((v.x + i) % AMod);
    end
    if (v.n == 0) begin
      exp_done = 2*Col + Row + 2;
      stalls = 0;
    end else begin
      found = 0;
      exp_done = -1;
      for (int k = s; k <= MaxK && found < v.n; k++) begin
        if (k > done_k && done_k > 0) break;
        if (vq[k] != 0) begin
          e_wr_edge.push_back(k); e_wr_addr.push_back((v.p + found) % AMod);
          found++;
          if (found == v.n) exp_done = k + 1;
        end
      end
      stalls = exp_done - s - v.n;
    end

    check("done_latency", 64'(done_k), 64'(exp_done));
    if (v.exp_lat >= 0) check("done_latency_table", 64'(done_k), 64'(v.exp_lat));
    check("xmem_read_count", 64'(rd_edge.size()), 64'(e_rd_edge.size()));
    for (int i = 0; i < rd_edge.size() && i < e_rd_edge.size(); i++) begin
      check($sformatf("xmem_read%0d_cycle", i), 64'(rd_edge[i]), 64'(e_rd_edge[i]));
      check($sformatf("xmem_read%0d_addr", i), 64'(rd_addr[i]), 64'(e_rd_addr[i]));
    end
    check("pmem_write_count", 64'(wr_edge.size()), 64'(v.n));
    for (int i = 0; i < wr_edge.size() && i < e_wr_edge.size(); i++) begin
      check($sformatf("pmem_write%0d_cycle", i), 64'(wr_edge[i]), 64'(e_wr_edge[i]));
      check($sformatf("pmem_write%0d_addr", i), 64'(wr_addr[i]), 64'(e_wr_addr[i]));
    end
    check("l0_wr_count", 64'(l0wr_n), 64'(Col + v.n));
    check("l0_wr_follows_read", 64'(pair_err), 64'd0);
    check("l0_rd_count", 64'(l0rd_n), 64'(Col + v.n));
    check("load_count", 64'(load_n), 64'(Col));
    check("execute_count", 64'(exec_n), 64'(v.n));
    check("idle_inst_cycles", 64'(idle_n), 64'(Row + stalls + 1));
    check("stray_fields", 64'(stray), 64'd0);
    check("busy_low_in_tile", 64'(busy_low), 64'd0);

    extra = 0; busy_low = 0; idle_n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ofifo_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      extra += int'(done);
      busy_low += int'(!busy);
      if (inst != IdleInst) idle_n++;
    end
    check("done_single_pulse", 64'(extra), 64'd0);
    check("busy_low_after_tile", 64'(busy_low), 64'd8);
    check("inst_idle_after_tile", 64'(idle_n), 64'd0);
  endtask

  task automatic reset_mid_exec();
    int extra, busy_hi;
    @(negedge clk);
    w_base = '0; x_base = 11'd16; p_base = 11'd100; n_x = 11'd4;
    start = 1'b1; ofifo_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Accepted at edge 0; edge 32 shows an EXEC instruction.
    repeat (31) @(posedge clk);
    #1;
    check("exec_before_reset", 64'(inst[ExecuteBit]), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("reset_inst_async", 64'(inst), 64'(IdleInst));
    check("reset_busy_async", 64'(busy), 64'd0);
    check("reset_done_async", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    extra = 0; busy_hi = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      extra += int'(done);
      busy_hi += int'(busy);
    end
    check("no_done_after_reset", 64'(extra), 64'd0);
    check("no_busy_after_reset", 64'(busy_hi), 64'd0);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t rv;
    vecs[0] = '{w: 0,    x: 16,   p: 100,  n: 4, mode: 0, poke: 1'b0, exp_lat: 39};
    vecs[1] = '{w: 0,    x: 16,   p: 100,  n: 4, mode: 1, poke: 1'b0, exp_lat: 45};
    vecs[2] = '{w: 5,    x: 300,  p: 7,    n: 0, mode: 0, poke: 1'b0, exp_lat: 26};
    vecs[3] = '{w: 2044, x: 2046, p: 2046, n: 4, mode: 0, poke: 1'b0, exp_lat: 39};
    vecs[4] = '{w: 0,    x: 16,   p: 100,  n: 4, mode: 0, poke: 1'b1, exp_lat: 39};

    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
    w_base = '0; x_base = '0; p_base = '0; n_x = '0;
    #12;
    check("reset_inst", 64'(inst), 64'(IdleInst));
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_tile(vecs[i]);
    reset_mid_exec();
    run_tile(vecs[0]);

    for (int t = 0; t < 6; t++) begin
      rv.w = int'($urandom_range(0, AMod - 1));
      rv.x = int'($urandom_range(0, AMod - 1));
      rv.p = int'($urandom_range(0, AMod - 1));
      rv.n = int'($urandom_range(0, 6));
      rv.mode = 2;
      rv.poke = 1'b0;
      rv.exp_lat = -1;
      run_tile(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
